stopwatch_display: RTL and testbench
====================================

// Module: stopwatch_display
// PURPOSE
//  Consumer end of the stopwatch counter's min/sec interface. Takes binary minute/second
//  values, converts each to two BCD digits and drives a 4-digit multiplexed 7-segment display.
//  Sits between the stopwatch counter and the board display pins; one digit is lit at a time.
// PARAMETERS
//  REFRESH_DIV  100000    clk cycles each digit stays lit (>=2)
//  BLINK_DIV    25000000  clk cycles per blink half-period (used only with BLINK_EN)
// PORTS
//  clk    in   1  system clock
//  rst    in   1  synchronous reset, active-high
//  min    in   6  minutes, binary; 0-59 valid
//  sec    in   6  seconds, binary; 0-59 valid
//  adj    in   1  adjust mode active
//  sel    in   1  adjust select: 1 = seconds field, 0 = minutes field
//  seg    out  7  segments {g,f,e,d,c,b,a}, active-low
//  an     out  4  digit anodes, active-low; an[0] = sec ones, an[3] = min tens
//  dp     out  1  decimal point, active-low; used as min/sec separator
// BEHAVIOUR
//  - Reset (rst=1 at posedge): an=4'b1111, seg=7'b1111111, dp=1. Refresh counter, digit
//    index and blink state all clear to 0. The snapshot registers clear to min=0, sec=0.
//  - Refresh counter: counts 0..REFRESH_DIV-1, then wraps.
//    - Digit index (0..3) advances on each wrap; 3 wraps to 0.
//  - Snapshot: min/sec are captured into holding registers on the cycle the index
//    becomes 0, and on the first cycle after reset.
//    - A full scan always shows one coherent value, so there is no tearing.
//  - BCD conversion on the snapshot: tens = v/10, ones = v%10.
//    - Snapshot values 60-63 are shown as dash (7'b0111111) on both digits of that field.
//  - Digit mapping:
//    - idx0 = sec ones
//    - idx1 = sec tens
//    - idx2 = min ones (dp=0 while idx2 is lit)
//    - idx3 = min tens
//  - Outputs are registered. an/seg/dp reflect the new index 1 cycle after the index
//    changes. After reset releases, the first an=4'b1110 appears 1 cycle later.
//  - Only one anode is low at a time; never more than one.
//  - Leading zeros are shown (minute tens 0 displays "0").
//  - Segment codes:
//    - 0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//    - 5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//  - Reset mid-scan: on the next cycle all outputs are off and idx=0. Scanning restarts
//    cleanly with a fresh snapshot.
// CONFIGURATION
//  BLINK_EN defined:
//    - A blink counter counts 0..BLINK_DIV-1 and toggles blink phase on each wrap.
//    - While adj=1 and blink phase=1, the anodes of the selected field are forced high
//      (sel=1: an[1:0]; sel=0: an[3:2]). The other field scans normally.
//    - On the rising edge of adj, the blink counter and blink phase clear to 0, so the
//      field is visible immediately.
//    - adj=0: no blanking.
//  BLINK_EN undefined:
//    - No blink logic is built. adj and sel are ignored and the display always scans normally.
// TESTING  (bench uses REFRESH_DIV=4, BLINK_DIV=16)
//  1. Hold rst 3 cycles -> an=1111, seg=1111111, dp=1 throughout. Release ->
//     an=1110 on the next cycle.
//  2. min=12, sec=34 -> each digit is held for 4 cycles, in this order:
//     - an=1110 seg=0011001
//     - an=1101 seg=0110000
//     - an=1011 seg=0100100 dp=0
//     - an=0111 seg=1111001
//  3. sec changes 34->35 while idx2 is lit -> the current scan still shows 4 on idx0;
//     the next scan shows seg=0010010 on idx0.
//  4. sec=61, min=5 -> idx0/idx1 seg=0111111; idx2 shows 5; idx3 shows 0 (1000000).
//  5. BLINK_EN, adj=1, sel=1:
//     - an[1:0] stays 11 for 16-cycle windows, alternating with normal scanning.
//     - an[3:2] scans unaffected.
//     - sel=0 moves the blanking to an[3:2].
//     - Without BLINK_EN, the same stimulus gives normal scanning.
//  6. Assert rst while idx2 is lit -> next cycle an=1111. After release, the scan
//     restarts at idx0 using the new snapshot.

Source files
------------

// File: rtl/stopwatch_display.sv
// stopwatch_display: multiplexed 4-digit 7-segment driver for a min:sec stopwatch
//
// Converts the binary minute and second values to BCD and drives one digit per
// refresh slot. The scan order is sec ones, sec tens, min ones, min tens.
//
// Ports:
//   clk, rst  system clock and synchronous active-high reset
//   min, sec  binary minutes/seconds in 0-59; 60-63 are shown as dashes
//   adj, sel  adjust mode and field select (1 = seconds, 0 = minutes); BLINK_EN only
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   an        digit anodes, active-low; an[0] = sec ones, an[3] = min tens
//   dp        decimal point, active-low; lit with the minute-ones digit as a separator
//
// Optional feature: define BLINK_EN to blink the selected field while adj is high.
module stopwatch_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          first_q;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d, mask;
    logic          dp_q, dp_d;
    logic          wrap;
    logic [5:0]    val;
    logic [3:0]    digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // The snapshot reloads only when the scan restarts at digit 0, so a full scan
    // never mixes two input values. On the first cycle after reset the snapshot
    // is still being loaded, so the live inputs are decoded directly.
    always_comb begin
        wrap  = cnt_q == CW'(REFRESH_DIV - 1);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q + {1'b0, wrap};
        min_d = (first_q || (wrap && idx_q == 2'd3)) ? min : min_q;
        sec_d = (first_q || (wrap && idx_q == 2'd3)) ? sec : sec_q;
        val   = idx_q[1] ? (first_q ? min : min_q) : (first_q ? sec : sec_q);
        digit = 4'(idx_q[0] ? val / 6'd10 : val % 6'd10);
        seg_d = val > 6'd59 ? 7'b0111111 : seg7(digit);
        an_d  = ~(4'b0001 << idx_q) | mask;
        dp_d  = idx_q != 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
            min_q   <= '0;
            sec_q   <= '0;
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            first_q <= 1'b0;
            min_q   <= min_d;
            sec_q   <= sec_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

`ifdef BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d, adj_q, adj_rise, bwrap;

    // Entering adjust restarts the blink in its visible phase; the rise cycle
    // itself is never blanked even if the old phase was the dark one.
    always_comb begin
        adj_rise = adj && !adj_q;
        bwrap    = bcnt_q == BW'(BLINK_DIV - 1);
        bcnt_d   = (adj_rise || bwrap) ? '0 : bcnt_q + 1'b1;
        blink_d  = !adj_rise && (blink_q ^ bwrap);
        mask     = (adj && blink_q && !adj_rise) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
            adj_q   <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
            adj_q   <= adj;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = adj ^ sel ^ (BLINK_DIV == 0);
    assign mask = 4'b0000;
`endif

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: scoreboard bench for stopwatch_display (REFRESH_DIV=4, BLINK_DIV=16)
module tb_stopwatch_display;
    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};
    localparam logic [6:0] DASH = 7'b0111111;
`ifdef BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] min = 6'd12;
    logic [5:0] sec = 6'd34;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    stopwatch_display #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk(clk), .rst(rst), .min(min), .sec(sec), .adj(adj), .sel(sel),
        .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic exp_t expect_digit(input int d, input int mn, input int sc, input logic [3:0] msk);
        exp_t e;
        int   v;
        v     = d >= 2 ? mn : sc;
        e.seg = v >= 60 ? DASH : SEG[(d % 2 == 1) ? v / 10 : v % 10];
        e.an  = 4'b1111;
        e.an[d] = 1'b0;
        e.an  = e.an | msk;
        e.dp  = d != 2;
        return e;
    endfunction

    task automatic push_scan(input int mn, input int sc);
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < 4; c++)
                sbq.push_back(expect_digit(d, mn, sc, 4'b0000));
    endtask

    task automatic drain(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL %s: scoreboard empty at cycle %0d", tag, i);
            end else begin
                e = sbq.pop_front();
                if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                    errors++;
                    $display("FAIL %s[%0d]: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                             tag, i, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
                errors++;
                $display("FAIL reset[%0d]: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
                         i, an, seg, dp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan;
        push_scan(12, 34);
        drain("scan_12_34", 16);
    endtask

    task automatic test_snapshot;
        push_scan(12, 34);
        drain("snap_hold", 9);
        sec = 6'd35;
        drain("snap_hold", 7);
        push_scan(12, 35);
        drain("snap_next", 8);
        min = 6'd5;
        sec = 6'd61;
        drain("snap_next", 8);
    endtask

    task automatic test_dash;
        push_scan(5, 61);
        drain("dash", 8);
        min = 6'd12;
        sec = 6'd34;
        drain("dash", 8);
    endtask

    task automatic test_blink;
        logic [3:0] msk;
        adj = 1'b1;
        sel = 1'b1;
        for (int k = 0; k < 96; k++) begin
            if (k == 64) sel = 1'b0;
            msk = 4'b0000;
            if (BLINK && k >= 1 && ((k - 1) / 16) % 2 == 1) msk = sel ? 4'b0011 : 4'b1100;
            sbq.push_back(expect_digit((k / 4) % 4, 12, 34, msk));
            drain(sel ? "blink_sec" : "blink_min", 1);
        end
        adj = 1'b0;
    endtask

    task automatic test_reset_mid;
        push_scan(12, 34);
        drain("mid_pre", 9);
        void'(sbq.pop_front());
        while (sbq.size() > 0) void'(sbq.pop_front());
        min = 6'd7;
        sec = 6'd9;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
                     an, seg, dp);
        end
        rst = 1'b0;
        push_scan(7, 9);
        drain("restart_7_9", 16);
    endtask

    initial begin
        test_reset;
        test_scan;
        test_snapshot;
        test_dash;
        test_blink;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
